// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath (fetch/decode/execute/writeback).
// Optional MC_MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_mem_go;
   logic [1:0]  w_alu_op;
   logic        w_pc_write;
   logic        w_ir_write;
   logic        w_mem_write;
   logic        w_reg_write;
   logic        w_illegal;

`ifdef MC_MEM_WAIT_EN
   assign w_mem_go = mem_ready;
`else
   logic w_unused;
   assign w_mem_go = 1'b1;
   assign w_unused = mem_ready;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = S_FETCH;
      w_alu_op    = 2'b00;
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_illegal   = 1'b0;
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      case (r_state)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            w_ir_write = w_mem_go;
            w_pc_write = w_mem_go;
            w_next     = w_mem_go ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               7'b0000011, 7'b0100011: w_next = S_MEMADR;
               7'b0110011:             w_next = S_EXECUTER;
               7'b0010011:             w_next = S_EXECUTEI;
               7'b1100011:             w_next = S_BRANCH;
               7'b1101111:             w_next = S_JAL;
               default: begin
                  w_next    = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            w_next  = w_mem_go ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            w_reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            w_mem_write = 1'b1;
            w_next      = w_mem_go ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            w_alu_op  = 2'b10;
            w_next    = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            w_alu_op  = 2'b10;
            w_next    = S_ALUWB;
         end
         S_ALUWB: w_reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a  = 2'b10;
            w_alu_op   = 2'b01;
            // funct3[0] distinguishes bne from beq
            w_pc_write = zero_flag ^ funct3[0];
         end
         S_JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            w_pc_write = 1'b1;
            w_next     = S_ALUWB;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_comb begin
      alu_control = 3'b000;
      case (w_alu_op)
         2'b01: alu_control = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (op[5] & funct7_5) ? 3'b001 : 3'b000;
               3'b010:  alu_control = 3'b101;
               3'b100:  alu_control = 3'b100;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'b000;
            endcase
         end
         default: alu_control = 3'b000;
      endcase
   end

   always_comb begin
      imm_src = 2'b00;
      case (op)
         7'b0100011: imm_src = 2'b01;
         7'b1100011: imm_src = 2'b10;
         7'b1101111: imm_src = 2'b11;
         default:    imm_src = 2'b00;
      endcase
   end

   // Strobes are suppressed for the whole reset window so an abandoned instruction writes nothing.
   assign pc_write   = w_pc_write  & ~reset;
   assign ir_write   = w_ir_write  & ~reset;
   assign mem_write  = w_mem_write & ~reset;
   assign reg_write  = w_reg_write & ~reset;
   assign illegal_op = w_illegal   & ~reset;
   assign state      = r_state;

endmodule
